// File: rtl/tp_pkg.sv
// tp_pkg -- shared definitions for the hiscore / CPU work-RAM arbiter.
//   TP_RAM_BASE   : hiscore address that maps onto work-RAM byte 0
//   TP_STARVE_LIM : default number of pending cycles before the CPU is stalled
//   TP_STARVE_W   : width of the starve counter
//   arb_state_t   : arbiter FSM states
package tp_pkg;

    localparam logic [15:0] TP_RAM_BASE   = 16'hA800;
    localparam int          TP_STARVE_LIM = 32;
    localparam int          TP_STARVE_W   = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STALL,
        ST_GRANT,
        ST_READ,
        ST_ACK,
        ST_RELEASE
    } arb_state_t;

endpackage

// File: rtl/tp_hs_addr_chk.sv
// tp_hs_addr_chk -- combinational decode of a hiscore address into the
// work-RAM window.
//   hs_address : 16-bit hiscore address
//   in_range   : 1 when RAM_BASE <= hs_address < RAM_BASE + 2^RAM_AW
//   ram_offset : hs_address - RAM_BASE, truncated to the RAM address width
module tp_hs_addr_chk
    import tp_pkg::*;
#(
    parameter logic [15:0] RAM_BASE = TP_RAM_BASE,
    parameter int          RAM_AW   = 11
) (
    input  logic [15:0]       hs_address,
    output logic              in_range,
    output logic [RAM_AW-1:0] ram_offset
);

    // One extra bit so a window ending at 0x10000 cannot wrap to zero.
    localparam logic [16:0] WIN_LO = {1'b0, RAM_BASE};
    localparam logic [16:0] WIN_HI = WIN_LO + (17'd1 << RAM_AW);

    always_comb begin
        in_range   = ({1'b0, hs_address} >= WIN_LO) && ({1'b0, hs_address} < WIN_HI);
        ram_offset = RAM_AW'(hs_address - RAM_BASE);
    end

endmodule

// File: rtl/tp_hiscore_arb.sv
// tp_hiscore_arb -- arbitrates a single-port work RAM between the game CPU
// and the hiscore save/restore engine.
//   clk_49m, reset          : clock and synchronous active-high reset
//   pause                   : game paused, hiscore may take the RAM at will
//   cpu_cs/addr/din/we      : CPU side of the work RAM
//   cpu_wait                : Z80 WAIT, high while hiscore owns the RAM
//   hs_req/address/data_in/write : hiscore request, held until hs_ack
//   hs_data_out, hs_ack     : read data and one-cycle completion pulse
//   ram_addr/din/we, ram_dout : shared RAM port (1-cycle registered read)
module tp_hiscore_arb
    import tp_pkg::*;
#(
    parameter logic [15:0] RAM_BASE   = TP_RAM_BASE,
    parameter int          RAM_AW     = 11,
    parameter int          STARVE_LIM = TP_STARVE_LIM
) (
    input  logic              clk_49m,
    input  logic              reset,
    input  logic              pause,
    input  logic              cpu_cs,
    input  logic [RAM_AW-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    input  logic              cpu_we,
    output logic              cpu_wait,
    input  logic              hs_req,
    input  logic [15:0]       hs_address,
    input  logic [7:0]        hs_data_in,
    input  logic              hs_write,
    output logic [7:0]        hs_data_out,
    output logic              hs_ack,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    input  logic [7:0]        ram_dout
);

    arb_state_t              state, state_nxt;
    logic [TP_STARVE_W-1:0]  starve_cnt;
    logic [RAM_AW-1:0]       hs_offset;
    logic [RAM_AW-1:0]       held_addr;
    logic                    held_write;
    logic                    in_range;
    logic                    grant_ok;
    logic                    starve_hit;
    logic                    oor_req;

    tp_hs_addr_chk #(
        .RAM_BASE (RAM_BASE),
        .RAM_AW   (RAM_AW)
    ) u_addr_chk (
        .hs_address (hs_address),
        .in_range   (in_range),
        .ram_offset (hs_offset)
    );

    assign grant_ok   = hs_req && in_range && (!cpu_cs || pause);
    assign oor_req    = hs_req && !in_range;
    assign starve_hit = (starve_cnt == TP_STARVE_W'(STARVE_LIM - 1));

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_49m) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned (which would infer a latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (oor_req)                              state_nxt = ST_ACK;
                else if (grant_ok)                        state_nxt = ST_GRANT;
                else if (hs_req && in_range && starve_hit) state_nxt = ST_STALL;
            end
            ST_STALL:   state_nxt = ST_GRANT;
            ST_GRANT:   state_nxt = ST_READ;
            ST_READ:    state_nxt = ST_ACK;
            ST_ACK:     state_nxt = ST_RELEASE;
            // A request still held after its ack is not serviced again.
            ST_RELEASE: if (!hs_req) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: the CPU owns the RAM port except in GRANT and READ.
    always_comb begin
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = cpu_we & cpu_cs;
        cpu_wait = 1'b0;
        hs_ack   = 1'b0;
        unique case (state)
            ST_STALL: cpu_wait = 1'b1;
            ST_GRANT: begin
                ram_addr = hs_offset;
                ram_din  = hs_data_in;
                ram_we   = hs_write;
                cpu_wait = 1'b1;
            end
            ST_READ: begin
                // Address held so the registered read data stays coherent
                // even if the requester drops hs_req after GRANT.
                ram_addr = held_addr;
                ram_din  = hs_data_in;
                ram_we   = 1'b0;
                cpu_wait = 1'b1;
            end
            ST_ACK:  hs_ack = 1'b1;
            default: ;
        endcase
        // No write may slip through in the reset cycle, even mid-GRANT.
        if (reset) ram_we = 1'b0;
    end

    // Datapath registers: starve counter, captured access, read data.
    always_ff @(posedge clk_49m) begin
        if (reset) begin
            starve_cnt  <= '0;
            held_addr   <= '0;
            held_write  <= 1'b0;
            hs_data_out <= 8'h00;
        end else begin
            if (state == ST_IDLE && hs_req && cpu_cs && !pause) begin
                if (starve_cnt != '1) starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end

            if (state == ST_GRANT) begin
                held_addr  <= hs_offset;
                held_write <= hs_write;
            end

            if (state == ST_IDLE && oor_req)        hs_data_out <= 8'hFF;
            else if (state == ST_READ && !held_write) hs_data_out <= ram_dout;
        end
    end

endmodule

// File: tb/tb_tp_hiscore_arb.sv
// Randomized scoreboard bench for tp_hiscore_arb with a behavioural RAM.
module tb_tp_hiscore_arb;

    localparam int AW   = 11;
    localparam int BASE = 'hA800;
    localparam int LIM  = 32;
    localparam int WIN  = 1 << AW;

    logic          clk_49m = 1'b0;
    logic          reset;
    logic          pause;
    logic          cpu_cs;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic          cpu_we;
    logic          cpu_wait;
    logic          hs_req;
    logic [15:0]   hs_address;
    logic [7:0]    hs_data_in;
    logic          hs_write;
    logic [7:0]    hs_data_out;
    logic          hs_ack;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic [7:0]    ram_dout;

    always #10 clk_49m = ~clk_49m;

    tp_hiscore_arb dut (
        .clk_49m     (clk_49m),
        .reset       (reset),
        .pause       (pause),
        .cpu_cs      (cpu_cs),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .cpu_we      (cpu_we),
        .cpu_wait    (cpu_wait),
        .hs_req      (hs_req),
        .hs_address  (hs_address),
        .hs_data_in  (hs_data_in),
        .hs_write    (hs_write),
        .hs_data_out (hs_data_out),
        .hs_ack      (hs_ack),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_we      (ram_we),
        .ram_dout    (ram_dout)
    );

    // Work RAM: synchronous write, registered read.
    logic [7:0] mem [WIN];
    always @(posedge clk_49m) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk_49m) cyc <= cyc + 1;

    // Reference state: expected RAM contents and last hiscore read result.
    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;
    exp_t       sb[$];
    logic [7:0] shadow [WIN];
    logic [7:0] last_out;
    int         wait_lo = 1;
    int         wait_hi = 0;
    int         we_cyc  = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: per-cycle wait/write expectations and ack scoreboard.
    always @(negedge clk_49m) begin : mon
        exp_t e;
        if (!reset) begin
            check("cpu_wait", 32'(cpu_wait), 32'(cyc >= wait_lo && cyc <= wait_hi));
            check("ram_we", 32'(ram_we), 32'(cyc == we_cyc));
            if (hs_ack) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("hs_data_out", 32'(hs_data_out), 32'(e.data));
                    check("ack_cycle", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    // One hiscore access with CPU activity held constant for its duration.
    task automatic do_txn(input logic [15:0] a, input logic [7:0] d, input logic wr,
                          input logic cs, input logic pz, input int hold, input bit drop);
        int   start, lat, idx;
        bit   inr, starve, got;
        exp_t e;
        @(posedge clk_49m); #1;
        cpu_cs     = cs;
        pause      = pz;
        cpu_addr   = AW'($urandom);
        hs_req     = 1'b1;
        hs_address = a;
        hs_data_in = d;
        hs_write   = wr;
        start      = cyc;
        inr    = (int'(a) >= BASE) && (int'(a) < BASE + WIN);
        starve = inr && cs && !pz;
        lat    = !inr ? 1 : (starve ? LIM + 3 : 3);
        idx    = int'(a) - BASE;
        if (!inr)     last_out = 8'hFF;
        else if (wr)  shadow[idx] = d;
        else          last_out = shadow[idx];
        e.data = last_out;
        e.due  = start + lat;
        sb.push_back(e);
        if (inr) begin
            wait_lo = start + (starve ? LIM : 1);
            wait_hi = start + lat - 1;
            we_cyc  = wr ? start + lat - 2 : -1;
        end else begin
            wait_lo = 1;
            wait_hi = 0;
            we_cyc  = -1;
        end
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk_49m);
            if (hs_ack) got = 1'b1;
            else begin
                @(posedge clk_49m); #1;
                if (drop && cyc == start + 1) hs_req = 1'b0;
            end
        end
        check("ack_seen", 32'(got), 32'd1);
        repeat (hold) begin
            @(posedge clk_49m); #1;
            cpu_addr = AW'($urandom);
        end
        @(posedge clk_49m); #1;
        hs_req   = 1'b0;
        hs_write = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk_49m); #1;
            cpu_cs   = 1'($urandom);
            pause    = 1'($urandom);
            cpu_addr = AW'($urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        for (int i = 0; i < WIN; i++) begin
            mem[i]    = 8'($urandom);
            shadow[i] = mem[i];
        end
        mem[16'h010]    = 8'h5A;
        shadow[16'h010] = 8'h5A;
        last_out   = 8'h00;
        reset      = 1'b1;
        pause      = 1'b0;
        cpu_cs     = 1'b0;
        cpu_addr   = '0;
        cpu_din    = 8'h00;
        cpu_we     = 1'b0;
        hs_req     = 1'b0;
        hs_address = 16'h0000;
        hs_data_in = 8'h00;
        hs_write   = 1'b0;
        repeat (3) @(posedge clk_49m);
        @(negedge clk_49m);
        check("rst_hs_ack", 32'(hs_ack), 32'd0);
        check("rst_cpu_wait", 32'(cpu_wait), 32'd0);
        check("rst_hs_data_out", 32'(hs_data_out), 32'h00);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        @(posedge clk_49m); #1;
        reset = 1'b0;

        // Directed: idle-CPU read, write then CPU readback, window edges.
        do_txn(16'hA810, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        do_txn(16'hAFFF, 8'h33, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        @(posedge clk_49m); #1;
        cpu_cs   = 1'b1;
        cpu_addr = 11'h7FF;
        @(posedge clk_49m); #1;
        cpu_cs = 1'b0;
        @(negedge clk_49m);
        check("cpu_readback", 32'(ram_dout), 32'h33);
        do_txn(16'hAFFF, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        do_txn(16'h8000, 8'h77, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        do_txn(16'hA7FF, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        do_txn(16'hB000, 8'h11, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        do_txn(16'hA800, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        // Starvation, pause override, early drop, request held in RELEASE.
        do_txn(16'hA810, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        do_txn(16'hA900, 8'hC3, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        do_txn(16'hA900, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        do_txn(16'hA810, 8'h00, 1'b0, 1'b0, 1'b0, 4, 1'b0);
        gap(3);

        // Reset while the read is in READ: the access is abandoned silently.
        @(posedge clk_49m); #1;
        cpu_cs     = 1'b0;
        pause      = 1'b0;
        hs_req     = 1'b1;
        hs_address = 16'hA820;
        hs_write   = 1'b0;
        start      = cyc;
        wait_lo    = start + 1;
        wait_hi    = start + 2;
        we_cyc     = -1;
        @(posedge clk_49m); #1;
        @(posedge clk_49m); #1;
        reset = 1'b1;
        @(posedge clk_49m); #1;
        hs_req = 1'b0;
        @(negedge clk_49m);
        check("abort_hs_ack", 32'(hs_ack), 32'd0);
        check("abort_cpu_wait", 32'(cpu_wait), 32'd0);
        check("abort_hs_data_out", 32'(hs_data_out), 32'h00);
        check("abort_ram_we", 32'(ram_we), 32'd0);
        @(posedge clk_49m); #1;
        reset    = 1'b0;
        last_out = 8'h00;
        gap(2);

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            logic [15:0] a;
            logic        cs, pz;
            if ($urandom_range(0, 7) == 0)
                a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, BASE - 1))
                                                : 16'($urandom_range(BASE + WIN, 'hFFFF));
            else
                a = 16'(BASE + $urandom_range(0, WIN - 1));
            cs = 1'($urandom);
            pz = ($urandom_range(0, 3) == 0);
            do_txn(a, 8'($urandom), 1'($urandom), cs, pz, $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0) && !(cs && !pz));
            gap($urandom_range(0, 3));
        end

        repeat (4) @(posedge clk_49m);
        @(negedge clk_49m);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tp_hiscore_arb.md
TP_HISCORE_ARB -- requirements
Module: tp_hiscore_arb

Interface
REQ-001 Parameters, one per line (name, default, meaning): RAM_BASE 16'hA800 = hiscore address of work-RAM byte 0; RAM_AW 11 = work-RAM address width (2 KB); STARVE_LIM 32 = pending cycles before the CPU is stalled.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; ports, one per line (name, direction, width, meaning):
- clk_49m  in  1  sole clock (49.152 MHz)
- reset  in  1  synchronous, active-high reset
- pause  in  1  game paused; hiscore access is always permitted while high
- cpu_cs  in  1  CPU selects work RAM this cycle
- cpu_addr  in  RAM_AW  CPU RAM address
- cpu_din  in  8  CPU write data
- cpu_we  in  1  CPU write strobe
- cpu_wait  out  1  CPU wait request (Z80 WAIT, active high)
- hs_req  in  1  hiscore access request, held until hs_ack
- hs_address  in  16  hiscore address
- hs_data_in  in  8  hiscore write data
- hs_write  in  1  1 = write, 0 = read
- hs_data_out  out  8  read data, valid from hs_ack onward
- hs_ack  out  1  one-cycle completion pulse
- ram_addr  out  RAM_AW  shared RAM address
- ram_din  out  8  shared RAM write data
- ram_we  out  1  shared RAM write enable
- ram_dout  in  8  shared RAM read data, registered, 1-cycle latency

Function
REQ-003 FSM states: IDLE, STALL, GRANT, READ, ACK, RELEASE.
REQ-004 In IDLE, STALL, ACK and RELEASE the RAM port SHALL be driven by the CPU: ram_addr=cpu_addr, ram_din=cpu_din, ram_we=cpu_we&cpu_cs.
REQ-005 In GRANT the RAM port SHALL be driven by hiscore: ram_addr=hs_address-RAM_BASE (low RAM_AW bits), ram_din=hs_data_in, ram_we=hs_write.
REQ-006 In READ, ram_we SHALL be 0 and ram_addr SHALL hold the GRANT value.
REQ-007 IDLE->GRANT when hs_req=1, the address is in range, and (cpu_cs=0 or pause=1).
REQ-008 IDLE->ACK directly when hs_req=1 and the address is out of range (hs_address<RAM_BASE or ≥RAM_BASE+2^RAM_AW); hs_data_out SHALL load 8'hFF and RAM SHALL not be written.
REQ-009 A 6-bit starve counter SHALL increment each IDLE cycle with hs_req=1, cpu_cs=1, pause=0, and clear otherwise; it SHALL saturate at 63.
REQ-010 IDLE->STALL when the starve counter equals STARVE_LIM-1 and the IDLE->GRANT condition is false; STALL->GRANT unconditionally after one cycle.
REQ-011 cpu_wait SHALL be 1 in STALL, GRANT and READ, and 0 otherwise.
REQ-012 GRANT->READ unconditionally; in READ, hs_data_out SHALL load ram_dout for reads and SHALL hold its value for writes; READ->ACK.
REQ-013 hs_ack SHALL be 1 only in ACK, for exactly one cycle; ACK->RELEASE.
REQ-014 RELEASE->IDLE when hs_req=0; a request held high is not re-serviced.
REQ-015 Latency: an in-range request accepted in IDLE at cycle N SHALL produce hs_ack at N+3.
REQ-016 If hs_req drops in GRANT or READ, the access SHALL complete and ack anyway.
REQ-017 pause=1 and cpu_cs=1 together SHALL grant hiscore; cpu_wait is then the only CPU protection.

Reset
REQ-018 On reset: state=IDLE, starve counter=0, hs_ack=0, cpu_wait=0, hs_data_out=8'h00, ram_we=0. Reset mid-access SHALL abort without asserting hs_ack.

Structure
REQ-019 The FSM state enum, RAM_BASE and the STARVE_LIM default SHALL live in the shared package tp_pkg.
REQ-020 A single sub-module, tp_hs_addr_chk, SHALL hold the combinational range check and offset subtraction.

Verification
REQ-021 Read with the CPU idle: RAM[0x010]=0x5A; hs_req with hs_address=0xA810, cpu_cs=0 -> hs_ack at N+3, hs_data_out=0x5A.
REQ-022 Write: hs_address=0xAFFF, data 0x33 -> RAM[0x7FF]=0x33; a CPU read of 0x7FF afterwards returns 0x33.
REQ-023 Out-of-range: hs_address=0x8000 -> hs_ack at N+1, hs_data_out=0xFF, ram_we never asserted.
REQ-024 Starvation: cpu_cs held at 1, pause=0, hs_req=1 -> cpu_wait rises after 32 pending cycles, hs_ack 3 cycles later, cpu_wait low in ACK.
REQ-025 Pause: pause=1, cpu_cs=1 -> GRANT on the next cycle, no STALL visit.
REQ-026 Reset asserted in READ -> no hs_ack, all outputs at reset values; hs_req held high through RELEASE -> exactly one hs_ack.
